// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the fetch stage and the decode controller.
package mips_pkg;

    // sll $0,$0,0: the bubble placed in IF/ID whenever no real instruction is present.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Primary opcodes (instr[31:26]) recognised by the controller.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0]).
    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_JR  = 6'h08;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_SLT = 6'h2A;

    // Fetch sequencer: IDLE for one cycle out of reset, FETCH while a request
    // is on the bus, HOLD while a fetched word waits in the skid register.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_select.sv
// Redirect selection for the fetch stage: picks the next PC source with
// priority jr > jump > taken branch and forces word alignment of the target.
module pc_select (
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] if_id_pc4_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    // Byte-offset bits of register/branch targets and the low PC+4 bits are
    // deliberately dropped; they are collected here so the intent is explicit.
    logic unused_bits;
    assign unused_bits = ^{jr_target_i[1:0], branch_target_i[1:0], if_id_pc4_i[27:0]};

    // Priority mux over the three redirect sources.
    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
        redirect_o = 1'b0;
        target_o   = '0;
        if (jr_i) begin
            redirect_o = 1'b1;
            target_o   = {jr_target_i[31:2], 2'b00};
        end else if (jump_i) begin
            redirect_o = 1'b1;
            target_o   = {if_id_pc4_i[31:28], jump_target_i, 2'b00};
        end else if (branch_taken_i) begin
            redirect_o = 1'b1;
            target_o   = {branch_target_i[31:2], 2'b00};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Issues word fetches
// over a req/ack handshake, buffers one word while decode stalls, and applies
// jr/jump/branch redirects, discarding any response already in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        fetch_busy
);
    import mips_pkg::*;

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc4_d;
    logic [31:0]  pending_q;      // redirect target to load once the killed response returns
    logic         kill_q;         // the outstanding request belongs to a squashed path
    logic [31:0]  skid_q;
    logic [31:0]  skid_pc4_q;
    logic [31:0]  if_id_instr_q;
    logic [31:0]  if_id_pc4_q;
    logic         if_id_valid_q;
    logic         imem_req_q;
    logic         redirect;
    logic [31:0]  redirect_target;

    assign pc4_d = pc_q + 32'd4;  // modulo 2^32: 0xFFFF_FFFC wraps to 0

    pc_select u_pc_select (
        .jr_i            (jr),
        .jr_target_i     (jr_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .if_id_pc4_i     (if_id_pc4_q),
        .redirect_o      (redirect),
        .target_o        (redirect_target)
    );

    // Fetch sequencer, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register sees pre-edge values of the others.
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pending_q     <= RESET_PC;
            kill_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
            // NOTE: skid_q/skid_pc4_q are data-only and never read outside HOLD, so they carry no reset.
        end else begin
            // A redirect always squashes the instruction in IF/ID, stall or not.
            if (redirect) begin
                if_id_instr_q <= NOP_INSTR;
                if_id_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                    if (redirect) pc_q <= redirect_target;
                end
                FETCH: begin
                    if (imem_ack) begin
                        kill_q <= 1'b0;
                        if (redirect) begin
                            pc_q <= redirect_target;
                        end else if (kill_q) begin
                            // Response of a squashed path: drop it and restart at the target.
                            pc_q <= pending_q;
                            if (!stall) begin
                                if_id_instr_q <= NOP_INSTR;
                                if_id_valid_q <= 1'b0;
                            end
                        end else if (stall) begin
                            skid_q     <= imem_rdata;
                            skid_pc4_q <= pc4_d;
                            pc_q       <= pc4_d;
                            state_q    <= HOLD;
                            imem_req_q <= 1'b0;
                        end else begin
                            if_id_instr_q <= imem_rdata;
                            if_id_pc4_q   <= pc4_d;
                            if_id_valid_q <= 1'b1;
                            pc_q          <= pc4_d;
                        end
                    end else if (redirect) begin
                        // Address must stay put until the ack; remember where to go next.
                        pending_q <= redirect_target;
                        kill_q    <= 1'b1;
                    end else if (!stall) begin
                        if_id_instr_q <= NOP_INSTR;
                        if_id_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q       <= redirect_target;
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end else if (!stall) begin
                        if_id_instr_q <= skid_q;
                        if_id_pc4_q   <= skid_pc4_q;
                        if_id_valid_q <= 1'b1;
                        state_q       <= FETCH;
                        imem_req_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign op          = if_id_instr_q[31:26];
    assign func        = if_id_instr_q[5:0];
    assign fetch_busy  = (state_q == FETCH) && !imem_ack;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Directed steps follow the expected
// behaviour cycle by cycle; a program-order reference model (next expected
// fetch address) checks every cycle, including a randomized phase.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        fetch_busy;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .op            (op),
        .func          (func),
        .fetch_busy    (fetch_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Outputs sampled at the falling edge.
    logic        obs_req;
    logic [31:0] obs_addr;
    logic [31:0] obs_instr;
    logic [31:0] obs_pc4;
    logic        obs_valid;
    logic [5:0]  obs_op;
    logic [5:0]  obs_func;

    // Memory model: data word at an address is the address itself.
    int          mem_wait = 0;   // wait cycles before ack (0 = same-cycle ack)
    logic        mem_rand = 1'b0;
    int          wait_cnt = 0;

    // Reference model: address of the next instruction decode must see.
    logic [31:0] m_addr;
    int          consumed = 0;
    logic        p_req;
    logic        p_ack;
    logic [31:0] p_addr;
    logic        p_redir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sample();
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_instr = if_id_instr;
        obs_pc4   = if_id_pc4;
        obs_valid = if_id_valid;
        obs_op    = op;
        obs_func  = func;
    endtask

    // Properties that hold on every cycle, derived from the model.
    task automatic cycle_checks();
        logic [31:0] exp_word;
        if (p_req && !p_ack) begin
            check("req_held", 32'(obs_req), 32'd1);
            check("addr_stable", obs_addr, p_addr);
        end
        if (obs_req) check("addr_align", 32'(obs_addr[1:0]), 32'd0);
        if (p_redir) check("flush_valid", 32'(obs_valid), 32'd0);
        exp_word = obs_valid ? m_addr : NOP;
        check("if_id_instr", obs_instr, exp_word);
        check("op", 32'(obs_op), 32'(exp_word[31:26]));
        check("func", 32'(obs_func), 32'(exp_word[5:0]));
        if (obs_valid) check("if_id_pc4", obs_pc4, m_addr + 32'd4);
    endtask

    // One clock cycle: drive inputs and memory response, update the model,
    // advance to the next falling edge and check.
    task automatic tick(input logic st, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [25:0] jt,
                        input logic jrr, input logic [31:0] jrt);
        logic        ack_v;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] pc4_m;
        ack_v = 1'b0;
        if (obs_req) begin
            if (mem_rand) ack_v = ($urandom_range(0, 2) != 0);
            else          ack_v = (wait_cnt == mem_wait);
            wait_cnt = ack_v ? 0 : wait_cnt + 1;
        end else begin
            wait_cnt = 0;
        end
        reset         = 1'b0;
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        jr            = jrr;
        jr_target     = jrt;
        imem_ack      = ack_v;
        imem_rdata    = ack_v ? obs_addr : $urandom;
        #1;
        check("fetch_busy", 32'(fetch_busy), 32'(obs_req & ~ack_v));
        // Program order: decode consumes the IF/ID word when not stalled,
        // then any redirect defines the next instruction.
        pc4_m = m_addr + 32'd4;
        redir = jrr | jp | br;
        tgt   = m_addr;
        if (jrr)     tgt = {jrt[31:2], 2'b00};
        else if (jp) tgt = {pc4_m[31:28], jt, 2'b00};
        else if (br) tgt = {bt[31:2], 2'b00};
        if (obs_valid && !st) begin
            m_addr = pc4_m;
            consumed++;
        end
        if (redir) m_addr = tgt;
        p_req   = obs_req;
        p_ack   = ack_v;
        p_addr  = obs_addr;
        p_redir = redir;
        @(negedge clk);
        sample();
        cycle_checks();
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    endtask

    // One cycle with reset held; an ack may be injected to test it is ignored.
    task automatic reset_tick(input logic ack_in);
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        jr            = 1'b0;
        jr_target     = '0;
        imem_ack      = ack_in;
        imem_rdata    = $urandom;
        @(negedge clk);
        sample();
        m_addr   = RESET_PC;
        p_req    = 1'b0;
        p_ack    = 1'b0;
        p_redir  = 1'b0;
        wait_cnt = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   32'(obs_req), 32'd0);
        check({tag, "_addr"},  obs_addr, RESET_PC);
        check({tag, "_valid"}, 32'(obs_valid), 32'd0);
        check({tag, "_instr"}, obs_instr, NOP);
        check({tag, "_pc4"},   obs_pc4, 32'd0);
        check({tag, "_op"},    32'(obs_op), 32'd0);
        check({tag, "_func"},  32'(obs_func), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t expected < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset.
        reset_tick(1'b0);
        reset_tick(1'b1);
        check_reset_state("reset");

        // Zero-wait memory: one fetch per cycle.
        mem_wait = 0;
        idle_tick();
        check("zw_addr0", obs_addr, 32'h0);
        check("zw_req0", 32'(obs_req), 32'd1);
        check("zw_valid0", 32'(obs_valid), 32'd0);
        idle_tick();
        check("zw_addr1", obs_addr, 32'h4);
        check("zw_valid1", 32'(obs_valid), 32'd1);
        check("zw_pc4_1", obs_pc4, 32'h4);
        idle_tick();
        check("zw_addr2", obs_addr, 32'h8);
        check("zw_pc4_2", obs_pc4, 32'h8);
        idle_tick();
        check("zw_addr3", obs_addr, 32'hC);
        check("zw_pc4_3", obs_pc4, 32'hC);

        // Two-cycle ack latency: a bubble between instructions.
        mem_wait = 1;
        idle_tick();
        check("lat_addr_a", obs_addr, 32'hC);
        check("lat_bubble_a", 32'(obs_valid), 32'd0);
        idle_tick();
        check("lat_addr_b", obs_addr, 32'h10);
        check("lat_instr_b", obs_instr, 32'hC);
        idle_tick();
        check("lat_addr_c", obs_addr, 32'h10);
        check("lat_bubble_c", 32'(obs_valid), 32'd0);
        idle_tick();
        check("lat_addr_d", obs_addr, 32'h14);
        check("lat_instr_d", obs_instr, 32'h10);

        // Taken branch while the request to 0x14 is pending.
        tick(1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'd0, 1'b0, 32'd0);
        check("br_addr_held", obs_addr, 32'h14);
        check("br_flush", 32'(obs_valid), 32'd0);
        idle_tick();
        check("br_new_addr", obs_addr, 32'h100);
        check("br_no_stale", obs_instr, NOP);
        idle_tick();
        idle_tick();
        check("br_target_instr", obs_instr, 32'h100);
        check("br_target_pc4", obs_pc4, 32'h104);

        // Stall for three cycles while the ack arrives.
        mem_wait = 0;
        tick(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        check("st_req_off", 32'(obs_req), 32'd0);
        check("st_hold0", obs_instr, 32'h100);
        tick(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        check("st_hold1", obs_instr, 32'h100);
        tick(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        check("st_hold2", obs_instr, 32'h100);
        idle_tick();
        check("st_skid_instr", obs_instr, 32'h104);
        check("st_skid_pc4", obs_pc4, 32'h108);
        check("st_next_addr", obs_addr, 32'h108);

        // jr beats a simultaneous jump; then jump beats a taken branch.
        tick(1'b0, 1'b1, 32'hA000_0004, 1'b0, 26'd0, 1'b0, 32'd0);
        idle_tick();
        check("jr_setup_pc4", obs_pc4, 32'hA000_0008);
        tick(1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0040, 1'b1, 32'h0000_2003);
        check("jr_wins", obs_addr, 32'h0000_2000);
        idle_tick();
        tick(1'b0, 1'b1, 32'h0000_0500, 1'b1, 26'h3FF_FFFF, 1'b0, 32'd0);
        check("jump_wins", obs_addr, 32'h0FFF_FFFC);

        // PC wrap at the top of the address space.
        idle_tick();
        tick(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'd0, 1'b0, 32'd0);
        check("wrap_top_addr", obs_addr, 32'hFFFF_FFFC);
        idle_tick();
        check("wrap_pc4", obs_pc4, 32'h0);
        check("wrap_addr", obs_addr, 32'h0);

        // Reset in the middle of an outstanding request.
        idle_tick();
        mem_wait = 3;
        idle_tick();
        check("mid_req_pending", obs_addr, 32'h4);
        reset_tick(1'b1);
        check_reset_state("mid_reset");
        reset_tick(1'b1);
        mem_wait = 0;
        idle_tick();
        check("rr_addr", obs_addr, RESET_PC);
        check("rr_valid", 32'(obs_valid), 32'd0);
        idle_tick();
        check("rr_first_valid", 32'(obs_valid), 32'd1);
        check("rr_first_pc4", obs_pc4, RESET_PC + 32'd4);

        // Randomized traffic against the program-order model.
        mem_rand = 1'b1;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic        st;
            r  = $urandom_range(0, 15);
            st = ($urandom_range(0, 3) == 0);
            tick(st, (r == 0 || r == 3), $urandom,
                 obs_valid && (r == 2 || r == 3), 26'($urandom),
                 (r == 1 || r == 3), $urandom);
        end
        check("rand_progress", 32'(consumed >= 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
